// File: rtl/relu_stream_reader.sv
// Read-side controller for the ReLU layer: enables it, waits for done, then
// walks every element (channel/row/column) and streams it out on valid/ready.
module relu_stream_reader #(
    parameter int DATA_WIDTH = 69,
    parameter int NUM_CH     = 8,
    parameter int MAP_X      = 24,
    parameter int MAP_Y      = 24,
    parameter int TIMEOUT    = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    output logic                          relu_enable,
    input  logic                          relu_done,
    output logic [$clog2(NUM_CH)-1:0]     rd_ch,
    output logic [$clog2(MAP_X)-1:0]      rd_row,
    output logic [$clog2(MAP_Y)-1:0]      rd_col,
    input  logic [DATA_WIDTH-1:0]         rd_data,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          out_last_map,
    output logic                          out_last,
    output logic                          busy,
    output logic                          pass_done,
    output logic                          err_neg,
    output logic                          err_timeout
);
    localparam int CH_W  = $clog2(NUM_CH);
    localparam int ROW_W = $clog2(MAP_X);
    localparam int COL_W = $clog2(MAP_Y);
    localparam int TO_W  = $clog2(TIMEOUT + 1);

    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NUM_CH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(MAP_X - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(MAP_Y - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_DONE,
        S_READ,
        S_DRAIN,
        S_FINISH
    } state_t;

    state_t                 r_state;
    logic                   r_relu_enable;
    logic [CH_W-1:0]        r_ch;
    logic [ROW_W-1:0]       r_row;
    logic [COL_W-1:0]       r_col;
    logic [TO_W-1:0]        r_tcnt;
    logic [DATA_WIDTH-1:0]  r_out_data;
    logic                   r_out_valid;
    logic                   r_out_last_map;
    logic                   r_out_last;
    logic                   r_pass_done;
    logic                   r_err_neg;
    logic                   r_err_timeout;

    logic w_load;
    logic w_map_end;
    logic w_final;

    // A new element may be loaded whenever the output register is empty or
    // its current beat is being consumed on this same edge.
    assign w_load    = !r_out_valid || out_ready;
    assign w_map_end = (r_row == ROW_LAST) && (r_col == COL_LAST);
    assign w_final   = w_map_end && (r_ch == CH_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_relu_enable  <= 1'b0;
            r_ch           <= '0;
            r_row          <= '0;
            r_col          <= '0;
            r_tcnt         <= '0;
            r_out_data     <= '0;
            r_out_valid    <= 1'b0;
            r_out_last_map <= 1'b0;
            r_out_last     <= 1'b0;
            r_pass_done    <= 1'b0;
            r_err_neg      <= 1'b0;
            r_err_timeout  <= 1'b0;
        end else begin
            r_pass_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state       <= S_WAIT_DONE;
                        r_relu_enable <= 1'b1;
                        r_ch          <= '0;
                        r_row         <= '0;
                        r_col         <= '0;
                        r_tcnt        <= '0;
                        r_err_neg     <= 1'b0;
                        r_err_timeout <= 1'b0;
                    end
                end
                S_WAIT_DONE: begin
                    if (relu_done) begin
                        r_state <= S_READ;
                    end else if (r_tcnt == TO_LAST) begin
                        r_err_timeout <= 1'b1;
                        r_relu_enable <= 1'b0;
                        r_pass_done   <= 1'b1;
                        r_state       <= S_FINISH;
                    end else begin
                        r_tcnt <= r_tcnt + 1'b1;
                    end
                end
                S_READ: begin
                    if (w_load) begin
                        r_out_data     <= rd_data;
                        r_out_valid    <= 1'b1;
                        r_out_last_map <= w_map_end;
                        r_out_last     <= w_final;
                        if (rd_data[DATA_WIDTH-1]) begin
                            r_err_neg <= 1'b1;
                        end
                        // Counters freeze on the final address once it is loaded.
                        if (w_final) begin
                            r_state <= S_DRAIN;
                        end else if (r_col == COL_LAST) begin
                            r_col <= '0;
                            if (r_row == ROW_LAST) begin
                                r_row <= '0;
                                r_ch  <= r_ch + 1'b1;
                            end else begin
                                r_row <= r_row + 1'b1;
                            end
                        end else begin
                            r_col <= r_col + 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (r_out_valid && out_ready) begin
                        r_out_valid    <= 1'b0;
                        r_out_last_map <= 1'b0;
                        r_out_last     <= 1'b0;
                        r_relu_enable  <= 1'b0;
                        r_pass_done    <= 1'b1;
                        r_state        <= S_FINISH;
                    end
                end
                S_FINISH: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign relu_enable  = r_relu_enable;
    assign rd_ch        = r_ch;
    assign rd_row       = r_row;
    assign rd_col       = r_col;
    assign out_data     = r_out_data;
    assign out_valid    = r_out_valid;
    assign out_last_map = r_out_last_map;
    assign out_last     = r_out_last;
    assign busy         = (r_state != S_IDLE);
    assign pass_done    = r_pass_done;
    assign err_neg      = r_err_neg;
    assign err_timeout  = r_err_timeout;

endmodule

// File: tb/tb_relu_stream_reader.sv
// Self-checking bench for relu_stream_reader: a ReLU model plus a scoreboard
// of expected beats, one task per scenario.
module tb_relu_stream_reader;
    localparam int DW      = 69;
    localparam int NBEATS  = 8 * 24 * 24;
    localparam int NEG_IDX = 3 * 576 + 5 * 24 + 7;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          lm;
        logic          l;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          relu_enable;
    logic          relu_done = 1'b0;
    logic [2:0]    rd_ch;
    logic [4:0]    rd_row;
    logic [4:0]    rd_col;
    logic [DW-1:0] rd_data;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          out_last_map;
    logic          out_last;
    logic          busy;
    logic          pass_done;
    logic          err_neg;
    logic          err_timeout;

    bit done_en  = 1'b1;
    bit neg_mode = 1'b0;
    int checks = 0;
    int errors = 0;
    beat_t q[$];

    relu_stream_reader dut (
        .clk(clk), .rst(rst), .start(start),
        .relu_enable(relu_enable), .relu_done(relu_done),
        .rd_ch(rd_ch), .rd_row(rd_row), .rd_col(rd_col), .rd_data(rd_data),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last_map(out_last_map), .out_last(out_last),
        .busy(busy), .pass_done(pass_done),
        .err_neg(err_neg), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    // ReLU layer model: done follows enable by one cycle.
    always @(posedge clk) relu_done <= done_en && relu_enable;

    function automatic logic [DW-1:0] elem_val(int ch, int row, int col, bit neg);
        logic [DW-1:0] v;
        v = DW'(ch * 576 + row * 24 + col);
        if (neg && ch == 3 && row == 5 && col == 7) v[DW-1] = 1'b1;
        return v;
    endfunction

    always_comb rd_data = elem_val(int'(rd_ch), int'(rd_row), int'(rd_col), neg_mode);

    task automatic check_all_zero(input string name);
        checks++;
        if ({relu_enable, out_valid, out_last_map, out_last, busy, pass_done,
             err_neg, err_timeout} !== 8'h00 || out_data !== '0 ||
            {rd_ch, rd_row, rd_col} !== 13'h0) begin
            errors++;
            $display("FAIL %s: flags=%b data=%0h addr=%0d/%0d/%0d required all zero", name,
                     {relu_enable, out_valid, out_last_map, out_last, busy, pass_done,
                      err_neg, err_timeout}, out_data, rd_ch, rd_row, rd_col);
        end
    endtask

    task automatic run_pass(input string name, input int pct, input bit spur, input int abort_at);
        beat_t e;
        beat_t prev;
        int hs = 0;
        int pd = 0;
        int last_hs = -1;
        int pd_cyc = -1;
        bit prev_stall = 1'b0;
        q.delete();
        for (int ch = 0; ch < 8; ch++)
            for (int row = 0; row < 24; row++)
                for (int col = 0; col < 24; col++) begin
                    e.d  = elem_val(ch, row, col, neg_mode);
                    e.lm = (row == 23 && col == 23);
                    e.l  = (row == 23 && col == 23 && ch == 7);
                    q.push_back(e);
                end
        prev = '0;
        for (int cyc = 0; cyc < 30000; cyc++) begin
            if (abort_at >= 0 && hs == abort_at) begin
                rst = 1'b1; start = 1'b0;
                @(negedge clk);
                check_all_zero({name, "_reset_outputs"});
                rst = 1'b0;
                repeat (3) @(negedge clk);
                checks++;
                if (pass_done !== 1'b0 || busy !== 1'b0) begin
                    errors++;
                    $display("FAIL %s_after_reset: pass_done=%b busy=%b required 0 0", name, pass_done, busy);
                end
                q.delete();
                return;
            end
            if (pass_done) begin
                pd++; pd_cyc = cyc; checks++;
                if (cyc != last_hs + 1 || relu_enable !== 1'b0 || hs != NBEATS) begin
                    errors++;
                    $display("FAIL %s_pass_done: cyc=%0d last_hs=%0d enable=%b beats=%0d required cyc=last_hs+1 enable=0 beats=%0d",
                             name, cyc, last_hs, relu_enable, hs, NBEATS);
                end
            end
            if (cyc == 1) begin
                checks++;
                if (err_neg !== 1'b0 || err_timeout !== 1'b0 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL %s_start_state: err_neg=%b err_timeout=%b busy=%b required 0 0 1",
                             name, err_neg, err_timeout, busy);
                end
            end
            if (cyc >= 1 && hs < NBEATS) begin
                checks++;
                if (relu_enable !== 1'b1) begin
                    errors++;
                    $display("FAIL %s_enable_held: cyc=%0d enable=%b required 1", name, cyc, relu_enable);
                end
            end
            if (prev_stall) begin
                checks++;
                if ({out_data, out_last_map, out_last} !== prev) begin
                    errors++;
                    $display("FAIL %s_stall_stable: beat=%0d got %0h required %0h", name, hs,
                             {out_data, out_last_map, out_last}, prev);
                end
            end
            if (pct >= 100 && hs > 0 && hs < NBEATS) begin
                checks++;
                if (out_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL %s_no_gap: beat=%0d out_valid=%b required 1", name, hs, out_valid);
                end
            end
            if (out_valid) begin
                checks++;
                if (err_neg !== (neg_mode && hs >= NEG_IDX)) begin
                    errors++;
                    $display("FAIL %s_err_neg: beat=%0d err_neg=%b required %b", name, hs, err_neg,
                             neg_mode && hs >= NEG_IDX);
                end
            end
            if (pd > 0 && cyc >= pd_cyc + 4) break;
            out_ready = (pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < pct);
            if (out_valid && out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL %s_extra_beat: beat=%0d data=%0h required no beat", name, hs, out_data);
                end else begin
                    e = q.pop_front();
                    if (out_data !== e.d || out_last_map !== e.lm || out_last !== e.l) begin
                        errors++;
                        $display("FAIL %s_beat: idx=%0d got data=%0h lm=%b l=%b required data=%0h lm=%b l=%b",
                                 name, hs, out_data, out_last_map, out_last, e.d, e.lm, e.l);
                    end
                end
                hs++; last_hs = cyc;
            end
            prev_stall = out_valid && !out_ready;
            prev = {out_data, out_last_map, out_last};
            start = (cyc == 0) || (spur && cyc == 2000);
            @(negedge clk);
        end
        start = 1'b0; out_ready = 1'b0;
        checks++;
        if (hs != NBEATS || pd != 1 || q.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_summary: beats=%0d pass_done=%0d left=%0d busy=%b required %0d 1 0 0",
                     name, hs, pd, q.size(), busy, NBEATS);
        end
        $display("pass %s: beats=%0d pass_done_pulses=%0d", name, hs, pd);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset_state");
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("idle_after_reset");
        $display("reset: checked");
    endtask

    task automatic test_timeout();
        int seen = -1;
        done_en = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= 25; c++) begin
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL timeout_no_valid: cyc=%0d out_valid=%b required 0", c, out_valid);
            end
            if (pass_done) begin
                seen = c;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (seen < 0 || seen > 18 || err_timeout !== 1'b1) begin
            errors++;
            $display("FAIL timeout_pulse: pass_done_cyc=%0d err_timeout=%b required <=18 and 1", seen, err_timeout);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || relu_enable !== 1'b0 || err_timeout !== 1'b1 || pass_done !== 1'b0) begin
            errors++;
            $display("FAIL timeout_idle: busy=%b enable=%b err_timeout=%b pass_done=%b required 0 0 1 0",
                     busy, relu_enable, err_timeout, pass_done);
        end
        done_en = 1'b1;
        $display("timeout: pass_done at cycle %0d", seen);
    endtask

    task automatic test_basic();
        run_pass("basic", 100, 1'b0, -1);
    endtask

    task automatic test_backpressure();
        run_pass("backpressure", 50, 1'b0, -1);
    endtask

    task automatic test_negative();
        neg_mode = 1'b1;
        run_pass("negative", 100, 1'b0, -1);
        checks++;
        if (err_neg !== 1'b1) begin
            errors++;
            $display("FAIL negative_sticky: err_neg=%b required 1", err_neg);
        end
        neg_mode = 1'b0;
    endtask

    task automatic test_reset_mid_pass();
        run_pass("reset_mid", 100, 1'b0, 1000);
        run_pass("restart", 100, 1'b0, -1);
    endtask

    task automatic test_spurious_start();
        run_pass("spurious", 100, 1'b1, -1);
    endtask

    initial begin
        test_reset();
        test_timeout();
        test_basic();
        test_backpressure();
        test_negative();
        test_reset_mid_pass();
        test_spurious_start();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/relu_stream_reader.md
Name: relu_stream_reader

Overview:
- Read-side controller for the 8-channel 24x24 ReLU layer.
- On `start`, asserts `relu_enable` and waits for `relu_done`.
- Keeps `relu_enable` held so the ReLU outputs stay valid, walks every element in channel/row/column order through an address port, and emits each element on a valid/ready stream toward the pooling stage.
- Flags any negative value read back and any `relu_done` timeout.

Parameters:
- DATA_WIDTH, 69, width of one ReLU result element (signed).
- NUM_CH, 8, number of feature maps.
- MAP_X, 24, rows per map.
- MAP_Y, 24, columns per map.
- TIMEOUT, 16, maximum cycles in WAIT_DONE before aborting.

Ports:
- clk  in  1  clock, all logic on posedge.
- rst  in  1  synchronous reset, active high.
- start  in  1  single-cycle request to begin a pass; ignored unless the FSM is in IDLE.
- relu_enable  out  1  enable to the ReLU layer.
- relu_done  in  1  done from the ReLU layer; stays high while enabled.
- rd_ch  out  3  channel index to the external element mux.
- rd_row  out  5  row index.
- rd_col  out  5  column index.
- rd_data  in  DATA_WIDTH  element at (rd_ch, rd_row, rd_col); combinational, same-cycle.
- out_data  out  DATA_WIDTH  stream data (registered).
- out_valid  out  1  stream valid.
- out_ready  in  1  stream ready.
- out_last_map  out  1  marks the last element of the current channel.
- out_last  out  1  marks the final element of the pass.
- busy  out  1  high in any state other than IDLE.
- pass_done  out  1  one-cycle pulse at the end of a pass.
- err_neg  out  1  sticky; a read element had its sign bit set.
- err_timeout  out  1  sticky; `relu_done` was not seen within TIMEOUT cycles.

Behaviour:
- Reset: every output is 0; FSM goes to IDLE; counters, timeout counter and both sticky flags are cleared. Reset mid-pass aborts immediately with no `pass_done`.
- FSM states: IDLE, WAIT_DONE, READ, DRAIN, FINISH.
  - IDLE: `start` moves to WAIT_DONE; `relu_enable` goes to 1 on that edge; counters load 0; `err_neg` and `err_timeout` clear.
  - WAIT_DONE:
    - `relu_done` = 1 moves to READ.
    - Otherwise the timeout counter increments. When it reaches TIMEOUT-1 with `relu_done` still 0, set `err_timeout` and go to FINISH.
  - READ: `relu_enable` held at 1. Each load cycle captures `rd_data` into `out_data`, sets `out_valid`, and advances the counters.
    - A load occurs when `out_valid` = 0, or when `out_ready` = 1 (the held beat is consumed that same cycle).
    - Counter order: column innermost, then row, then channel. `rd_col` wraps MAP_Y-1 to 0 and increments `rd_row`; `rd_row` wraps MAP_X-1 to 0 and increments `rd_ch`.
    - `out_last_map` is registered with the beat: 1 when the loaded element has row = MAP_X-1 and col = MAP_Y-1.
    - `out_last` is registered with the beat: 1 when the loaded element additionally has ch = NUM_CH-1.
    - Loading the final element goes to DRAIN; the counters stay at the final address.
    - `err_neg` sets if `rd_data[DATA_WIDTH-1]` = 1 on any load cycle.
  - DRAIN: `relu_enable` stays 1; wait for `out_valid` && `out_ready`, then clear `out_valid` and go to FINISH.
  - FINISH: `relu_enable` = 0; `pass_done` = 1 for exactly this one cycle; next state IDLE.
- Stream rules:
  - `out_data`, `out_last_map` and `out_last` are stable while `out_valid` && !`out_ready`.
  - No bubbles while `out_ready` is held at 1.
  - `out_valid` never rises outside READ.
- Latency and throughput:
  - First `out_valid` occurs 1 cycle after the READ-entry cycle.
  - With `out_ready` = 1 throughout, a full pass is NUM_CH*MAP_X*MAP_Y = 4608 beats on consecutive cycles.
- `start` while `busy` = 1 is ignored.
- `relu_done` dropping during READ has no effect on the FSM. The ReLU layer only clears its outputs when `relu_enable` is low, so data remains valid.
- The sticky flags hold their value until the next accepted `start` or reset.

Test Plan:
- Basic pass: reset, then `start`; ReLU model raises `relu_done` 1 cycle after enable; `out_ready` = 1; each element value = ch*576+row*24+col. Required: 4608 in-order beats with no gaps; `out_last_map` on beats 575, 1151, …, 4607; `out_last` only on beat 4607; `pass_done` pulses once, 1 cycle after the last handshake; `relu_enable` low from FINISH onward.
- Backpressure: `out_ready` random at 50%. Required: identical data sequence; `out_data` held stable while stalled; total handshakes = 4608; `relu_enable` stays 1 until DRAIN completes.
- Timeout: `relu_done` held at 0, TIMEOUT = 16. Required: `err_timeout` = 1 and a `pass_done` pulse at most 18 cycles after `start`; zero `out_valid` beats; back in IDLE.
- Negative data: element (ch 3, row 5, col 7) has its sign bit set. Required: that value is still streamed unchanged; `err_neg` rises on its load cycle and stays 1; the next `start` clears it.
- Reset mid-pass: assert `rst` at beat 1000. Required: all outputs 0 on the following cycle; no `pass_done`; a fresh `start` restarts at (0,0,0).
- Spurious start: pulse `start` during READ. Required: no change in sequence or counters; exactly one `pass_done`.
